// File: rtl/eval_iris_trainer.sv
// eval_iris_trainer: drives a 16-entry learner through epochs of x/y samples until it reproduces target (DONE) or EPOCH_MAX runs out (FAIL)
module eval_iris_trainer #(
  parameter int EPOCH_MAX = 8,
  parameter bit SHUFFLE = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        abort,
  input  logic [15:0] target,
  input  logic        prediction,
  output logic [3:0]  x,
  output logic        y,
  output logic        busy,
  output logic        done,
  output logic        converged,
  output logic [3:0]  epochs,
  output logic [4:0]  last_err
);
  typedef enum logic [1:0] {IDLE, TRAIN, DONE, FAIL} state_t;
  state_t state, state_n;
  logic [15:0] tgt_q;
  logic [3:0] idx;
  logic [4:0] err, total;
  logic go, last;
  assign busy = state == TRAIN;
  assign done = state == DONE || state == FAIL;
  assign converged = state == DONE;
  assign x = busy ? idx ^ (SHUFFLE ? epochs : 4'd0) : 4'd0;
  assign y = busy ? tgt_q[x] : prediction;
  assign total = err + {4'd0, prediction != y};
  assign go = !abort && !busy && start;
  assign last = busy && idx == 4'd15;
  always_comb begin
    state_n = abort ? IDLE :
              go ? TRAIN :
              !last ? state :
              total == 5'd0 ? DONE :
              epochs + 4'd1 == 4'(EPOCH_MAX) ? FAIL : TRAIN;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      tgt_q <= '0;
      idx <= '0;
      err <= '0;
      epochs <= '0;
      last_err <= '0;
    end else begin
      state <= state_n;
      if (go) begin
        tgt_q <= target;
        idx <= '0;
        err <= '0;
        epochs <= '0;
      end else if (busy && !abort) begin
        idx <= idx + 4'd1;
        err <= last ? 5'd0 : total;
        if (last) begin
          last_err <= total;
          epochs <= epochs + 4'd1;
        end
      end
    end
  end
endmodule

// File: tb/tb_eval_iris_trainer.sv
// tb_eval_iris_trainer: directed and random runs of two trainer instances against an epoch-level reference model
`define CHK(tag, obs, exp) begin \
  n_assert++; \
  assert ((obs) === (exp)) else begin \
    n_fail++; \
    $error("FAIL %s: observed %0h expected %0h", tag, (obs), (exp)); \
  end \
end

module tb_eval_iris_trainer;
  logic clk, rst_n;
  logic start[2], abort[2], load[2], stuck[2];
  logic [15:0] target, load_val;
  logic [3:0] x[2], epochs[2];
  logic y[2], busy[2], done[2], converged[2], pred[2];
  logic [4:0] last_err[2];
  logic [15:0] tbl_v[2];
  int n_assert, n_fail;
  int prev_last[2];

  for (genvar g = 0; g < 2; g++) begin : u
    logic [15:0] tbl;
    eval_iris_trainer #(.EPOCH_MAX(g == 1 ? 8 : 3), .SHUFFLE(g == 1)) dut (
      .clk(clk), .rst_n(rst_n), .start(start[g]), .abort(abort[g]),
      .target(target), .prediction(pred[g]), .x(x[g]), .y(y[g]),
      .busy(busy[g]), .done(done[g]), .converged(converged[g]),
      .epochs(epochs[g]), .last_err(last_err[g])
    );
    always @(posedge clk)
      if (load[g]) tbl <= load_val;
      else tbl[x[g]] <= y[g];
    assign pred[g] = stuck[g] | tbl[x[g]];
    assign tbl_v[g] = tbl;
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void model(input int d, input logic [15:0] t, input logic [15:0] init,
                                input bit st, output int ep, output int lst, output bit conv);
    logic [15:0] l;
    int em, err;
    logic [3:0] a;
    l = init;
    em = d ? 8 : 3;
    ep = 0;
    lst = 0;
    conv = 0;
    while (1) begin
      err = 0;
      for (int i = 0; i < 16; i++) begin
        a = 4'(i) ^ (d == 1 ? 4'(ep) : 4'd0);
        if ((st ? 1'b1 : l[a]) != t[a]) err++;
        l[a] = t[a];
      end
      ep++;
      lst = err;
      if (err == 0) begin conv = 1; break; end
      if (ep == em) break;
    end
  endfunction

  task automatic load_learner(input int d, input logic [15:0] v, input bit st);
    @(negedge clk);
    load_val = v;
    load[d] = 1'b1;
    stuck[d] = st;
    @(negedge clk);
    load[d] = 1'b0;
  endtask

  task automatic run_case(input int d, input logic [15:0] t, input logic [15:0] init,
                          input bit st, output int cyc);
    int ep, lst;
    bit conv;
    logic [3:0] xe;
    load_learner(d, init, st);
    model(d, t, init, st, ep, lst, conv);
    target = t;
    start[d] = 1'b1;
    @(negedge clk);
    start[d] = 1'b0;
    `CHK("busy_after_start", busy[d], 1'b1)
    cyc = 0;
    while (busy[d] && cyc < 300) begin
      xe = 4'(cyc % 16) ^ (d == 1 ? 4'(cyc / 16) : 4'd0);
      `CHK("x_seq", x[d], xe)
      `CHK("y_label", y[d], t[xe])
      target = 16'($urandom);
      start[d] = (cyc == 20);
      @(negedge clk);
      cyc++;
    end
    start[d] = 1'b0;
    target = t;
    `CHK("cycles", cyc, ep * 16)
    `CHK("done", done[d], 1'b1)
    `CHK("converged", converged[d], conv)
    `CHK("epochs", epochs[d], 4'(ep))
    `CHK("last_err", last_err[d], 5'(lst))
    `CHK("x_idle", x[d], 4'd0)
    `CHK("y_follows", y[d], pred[d])
    prev_last[d] = lst;
  endtask

  initial begin
    int cyc;
    logic [15:0] snap, t, init;
    int d;
    bit st;
    n_assert = 0;
    n_fail = 0;
    target = '0;
    load_val = '0;
    for (int i = 0; i < 2; i++) begin
      start[i] = 0; abort[i] = 0; load[i] = 0; stuck[i] = 0; prev_last[i] = 0;
    end
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      `CHK("rst_busy", busy[i], 1'b0)
      `CHK("rst_done", done[i], 1'b0)
      `CHK("rst_conv", converged[i], 1'b0)
      `CHK("rst_epochs", epochs[i], 4'd0)
      `CHK("rst_last_err", last_err[i], 5'd0)
      `CHK("rst_x", x[i], 4'd0)
    end
    @(negedge clk);
    rst_n = 1'b1;
    load_learner(0, 16'h0000, 0);
    load_learner(1, 16'h0000, 0);

    run_case(0, 16'hA5A5, 16'h0000, 0, cyc);
    `CHK("a5a5_cycles", cyc, 32)
    `CHK("a5a5_epochs", epochs[0], 4'd2)
    `CHK("a5a5_conv", converged[0], 1'b1)

    run_case(0, 16'h3C3C, 16'h3C3C, 0, cyc);
    `CHK("3c3c_cycles", cyc, 16)
    `CHK("3c3c_epochs", epochs[0], 4'd1)
    `CHK("3c3c_last_err", last_err[0], 5'd0)

    run_case(0, 16'h0000, 16'h0000, 1, cyc);
    `CHK("stuck_cycles", cyc, 48)
    `CHK("stuck_done", done[0], 1'b1)
    `CHK("stuck_conv", converged[0], 1'b0)
    `CHK("stuck_epochs", epochs[0], 4'd3)
    `CHK("stuck_last_err", last_err[0], 5'd16)

    load_learner(0, 16'h0000, 0);
    target = 16'hA5A5;
    start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    repeat (4) @(negedge clk);
    abort[0] = 1'b1;
    @(negedge clk);
    abort[0] = 1'b0;
    `CHK("abort_busy", busy[0], 1'b0)
    `CHK("abort_done", done[0], 1'b0)
    `CHK("abort_conv", converged[0], 1'b0)
    `CHK("abort_x", x[0], 4'd0)
    `CHK("abort_y", y[0], pred[0])
    `CHK("abort_epochs", epochs[0], 4'd0)
    `CHK("abort_last_err", last_err[0], 5'(prev_last[0]))
    snap = tbl_v[0];
    repeat (20) @(negedge clk);
    `CHK("abort_table_held", tbl_v[0], snap)
    `CHK("abort_still_idle", busy[0], 1'b0)

    run_case(1, 16'hFFFF, 16'h0000, 0, cyc);
    `CHK("shuf_cycles", cyc, 32)
    `CHK("shuf_epochs", epochs[1], 4'd2)
    start[1] = 1'b1;
    abort[1] = 1'b1;
    @(negedge clk);
    start[1] = 1'b0;
    abort[1] = 1'b0;
    `CHK("sa_done", done[1], 1'b0)
    `CHK("sa_busy", busy[1], 1'b0)
    `CHK("sa_epochs", epochs[1], 4'd2)
    @(negedge clk);
    `CHK("sa_busy2", busy[1], 1'b0)

    run_case(0, 16'h0000, 16'h0000, 1, cyc);
    load_learner(0, 16'h0000, 0);
    target = 16'hA5A5;
    start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    repeat (20) @(negedge clk);
    `CHK("pre_rst_epochs", epochs[0], 4'd1)
    #3;
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      `CHK("arst_busy", busy[i], 1'b0)
      `CHK("arst_done", done[i], 1'b0)
      `CHK("arst_conv", converged[i], 1'b0)
      `CHK("arst_epochs", epochs[i], 4'd0)
      `CHK("arst_last_err", last_err[i], 5'd0)
      `CHK("arst_x", x[i], 4'd0)
      `CHK("arst_y", y[i], pred[i])
      prev_last[i] = 0;
    end
    @(negedge clk);
    rst_n = 1'b1;
    start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    `CHK("first_start_after_rst", busy[0], 1'b1)
    abort[0] = 1'b1;
    @(negedge clk);
    abort[0] = 1'b0;

    for (int k = 0; k < 10; k++) begin
      d = int'($urandom_range(0, 1));
      t = 16'($urandom);
      init = ($urandom_range(0, 2) == 0) ? t : 16'($urandom);
      st = ($urandom_range(0, 3) == 0);
      run_case(d, t, init, st, cyc);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
